// File: rtl/mbscore_irq_arbiter_pkg.sv
// Shared constants for the MBScore interrupt controller: default source map,
// vector layout and the 2-bit dispatch FSM encoding.
package mbscore_irq_arbiter_pkg;

  localparam int INT_NUM_SRC    = 5;
  localparam int INT_VEC_BASE   = 'h100;
  localparam int INT_VEC_STRIDE = 'h10;

  // Peripheral source indices; vector address is derived from these
  localparam int INT_KBD_ID     = 0;
  localparam int INT_MOUSE_ID   = 1;
  localparam int INT_UART_ID    = 2;
  localparam int INT_STORAGE_ID = 3;
  localparam int INT_ETH_ID     = 4;

  typedef logic [1:0] irq_state_t;

  localparam irq_state_t ST_IDLE    = 2'd0;
  localparam irq_state_t ST_REQ     = 2'd1;
  localparam irq_state_t ST_JUMP    = 2'd2;
  localparam irq_state_t ST_SERVICE = 2'd3;

endpackage

// File: rtl/mbscore_irq_prio_enc.sv
// Combinational winner picker: lowest eligible id (fixed mode) or first
// eligible id at or above the rotating pointer (round-robin mode).
module mbscore_irq_prio_enc #(
  parameter int NUM_SRC   = 5,
  parameter int PRIO_MODE = 0,
  localparam int ID_W     = $clog2(NUM_SRC > 1 ? NUM_SRC : 2)
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  logic [ID_W:0] base;
  logic [ID_W:0] cand;

  // Scan offsets from the far end down so the nearest hit is written last
  always_comb begin
    valid = |eligible;
    id    = '0;
    cand  = '0;
    base  = (PRIO_MODE != 0) ? {1'b0, ptr} : '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = base + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(NUM_SRC)) begin
        cand = cand - (ID_W + 1)'(NUM_SRC);
      end
      if (eligible[cand[ID_W-1:0]]) begin
        id = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mbscore_irq_arbiter.sv
// MBScore interrupt controller: synchronises requests, tracks pending/mask,
// arbitrates and drives the core stall / vector-jump handshake.
module mbscore_irq_arbiter
  import mbscore_irq_arbiter_pkg::*;
#(
  parameter int                  NUM_SRC     = INT_NUM_SRC,
  parameter int                  ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE  = ADDR_WIDTH'(INT_VEC_BASE),
  parameter logic [ADDR_WIDTH-1:0] VEC_STRIDE = ADDR_WIDTH'(INT_VEC_STRIDE),
  parameter logic [NUM_SRC-1:0]  EDGE_MASK   = '1,
  parameter logic [NUM_SRC-1:0]  MASK_RST    = '0,
  parameter int                  PRIO_MODE   = 0,
  parameter int                  SYNC_STAGES = 2,
  localparam int                 ID_W        = $clog2(NUM_SRC > 1 ? NUM_SRC : 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    irq_src,
  input  logic                  int_en_n,
  input  logic                  mask_we,
  input  logic [NUM_SRC-1:0]    mask_wdata,
  input  logic                  core_ready,
  input  logic                  int_done,
  output logic                  stop,
  output logic                  set_intr,
  output logic                  int_jump,
  output logic [ADDR_WIDTH-1:0] int_addr,
  output logic [ID_W-1:0]       int_id,
  output logic [NUM_SRC-1:0]    pending
);

  logic [NUM_SRC-1:0] sync_reg [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_prev_reg;
  logic [NUM_SRC-1:0] edge_pend_reg;
  logic [NUM_SRC-1:0] edge_pend_next;
  logic [NUM_SRC-1:0] mask_reg;
  logic [NUM_SRC-1:0] sync_out;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] eligible;
  irq_state_t         state_reg;
  logic [ID_W-1:0]    id_reg;
  logic [ID_W-1:0]    ptr_reg;
  logic               enc_valid;
  logic [ID_W-1:0]    enc_id;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign rise     = sync_out & ~sync_prev_reg;

  always_comb begin
    clr = '0;
    if (state_reg == ST_JUMP) begin
      clr[id_reg] = 1'b1;
    end
  end

  // A fresh edge in the dispatch cycle outranks the clear
  assign edge_pend_next = ((edge_pend_reg & ~clr) | rise) & EDGE_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= '0;
      end
      sync_prev_reg <= '0;
      edge_pend_reg <= '0;
    end else begin
      sync_reg[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
      sync_prev_reg <= sync_out;
      edge_pend_reg <= edge_pend_next;
    end
  end

  assign pending  = (edge_pend_reg & EDGE_MASK) | (sync_out & ~EDGE_MASK);
  assign eligible = pending & ~mask_reg & {NUM_SRC{~int_en_n}};

  mbscore_irq_prio_enc #(
    .NUM_SRC   (NUM_SRC),
    .PRIO_MODE (PRIO_MODE)
  ) u_prio_enc (
    .eligible (eligible),
    .ptr      (ptr_reg),
    .valid    (enc_valid),
    .id       (enc_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      id_reg    <= '0;
      ptr_reg   <= '0;
      mask_reg  <= MASK_RST;
    end else begin
      if (mask_we) begin
        mask_reg <= mask_wdata;
      end
      case (state_reg)
        ST_IDLE: begin
          if (enc_valid) begin
            state_reg <= ST_REQ;
            id_reg    <= enc_id;
          end
        end
        ST_REQ: begin
          if (int_en_n) begin
            state_reg <= ST_IDLE;
            id_reg    <= '0;
          end else if (core_ready) begin
            state_reg <= ST_JUMP;
          end
        end
        ST_JUMP: begin
          state_reg <= ST_SERVICE;
          if (PRIO_MODE != 0) begin
            ptr_reg <= (id_reg == ID_W'(NUM_SRC - 1)) ? '0 : id_reg + 1'b1;
          end
        end
        ST_SERVICE: begin
          if (int_done) begin
            state_reg <= ST_IDLE;
            id_reg    <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign stop     = (state_reg == ST_REQ) || (state_reg == ST_JUMP);
  assign set_intr = (state_reg == ST_JUMP);
  assign int_jump = (state_reg == ST_JUMP);
  assign int_id   = id_reg;
  assign int_addr = (state_reg == ST_JUMP) ?
                    VEC_BASE + ADDR_WIDTH'(id_reg) * VEC_STRIDE : '0;

endmodule
